// File: rtl/fp16_servo_pwm.sv
// FP16 activation to hobby-servo PWM: handshake, 3-stage decode/scale pipeline,
// and a frame generator that applies new pulse widths only at frame boundaries.
module fp16_servo_pwm #(
  parameter int unsigned TICKS_PER_US = 50,
  parameter int unsigned PERIOD_US    = 20000,
  parameter int unsigned CENTER_US    = 1500,
  parameter int unsigned RANGE_US     = 500,
  parameter int unsigned CNT_W        = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_val,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pwm,
  output logic             frame_start,
  output logic [CNT_W-1:0] pulse_ticks
);

  localparam int unsigned PERIOD_T = TICKS_PER_US * PERIOD_US;
  localparam int unsigned CENTER_T = TICKS_PER_US * CENTER_US;
  localparam int unsigned RANGE_T  = TICKS_PER_US * RANGE_US;
  localparam int unsigned MAG_W    = 11;
  localparam int unsigned PROD_W   = MAG_W + CNT_W;

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_T - 1);
  localparam logic [CNT_W-1:0] CENTER_W    = CNT_W'(CENTER_T);

  logic             accept;
  logic             readyNext;

  logic             s0Valid;
  logic [15:0]      s0Val;
  logic             s1Valid;
  logic             s1Sign;
  logic [MAG_W-1:0] s1Mag;

  logic [4:0]       decExp;
  logic [9:0]       decMan;
  logic             decSign;
  logic [MAG_W-1:0] decMag;

  logic [PROD_W-1:0] prod;
  logic [CNT_W-1:0]  offset;
  logic [CNT_W-1:0]  pendNext;

  logic [CNT_W-1:0] frameCnt;
  logic             wrap;
  logic [CNT_W-1:0] activeW;
  logic [CNT_W-1:0] pendW;
  logic             pendFlag;

  assign accept    = in_valid & in_ready;
  // Ready drops whenever either stage will hold data after this edge.
  assign readyNext = ~(accept | s0Valid);

  assign decExp = s0Val[14:10];
  assign decMan = s0Val[9:0];

  // FP16 to Q0.10 magnitude: subnormals flush to zero, >=1.0 clamps, NaN is centered.
  always_comb begin
    decSign = s0Val[15];
    decMag  = '0;
    if (decExp == 5'd31 && decMan != 10'd0) begin
      decSign = 1'b0;
      decMag  = '0;
    end else if (decExp >= 5'd15) begin
      decMag = MAG_W'(1024);
    end else if (decExp != 5'd0) begin
      decMag = {1'b1, decMan} >> (5'd15 - decExp);
    end
  end

  assign prod     = PROD_W'(s1Mag) * PROD_W'(RANGE_T);
  assign offset   = CNT_W'(prod >> 10);
  assign pendNext = s1Sign ? (CENTER_W - offset) : (CENTER_W + offset);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      s0Valid  <= 1'b0;
      s0Val    <= '0;
      s1Valid  <= 1'b0;
      s1Sign   <= 1'b0;
      s1Mag    <= '0;
    end else begin
      in_ready <= readyNext;
      s0Valid  <= accept;
      if (accept) s0Val <= in_val;
      s1Valid  <= s0Valid;
      if (s0Valid) begin
        s1Sign <= decSign;
        s1Mag  <= decMag;
      end
    end
  end

  assign wrap        = (frameCnt == PERIOD_LAST);
  assign pulse_ticks = activeW;

  // Frame generator; a pending write on the wrap edge is held for the next wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameCnt    <= '0;
      frame_start <= 1'b0;
      pwm         <= 1'b0;
      activeW     <= CENTER_W;
      pendW       <= CENTER_W;
      pendFlag    <= 1'b0;
    end else begin
      frameCnt    <= wrap ? '0 : frameCnt + CNT_W'(1);
      frame_start <= wrap;
      pwm         <= (frameCnt < activeW);
      if (wrap && pendFlag) begin
        activeW  <= pendW;
        pendFlag <= 1'b0;
      end
      if (s1Valid) begin
        pendW    <= pendNext;
        pendFlag <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fp16_servo_pwm.md
Name: fp16_servo_pwm

Overview:
Downstream consumer of the activation stage. It takes one FP16 activation output per leg joint and converts it, through a handshake, into a standard hobby-servo PWM signal. The mapping is -1.0 → 1000 us, 0 → 1500 us, +1.0 → 2000 us, over a 20 ms frame. New widths are applied only at frame boundaries, so pulses are never truncated or glitched.

Parameters:
TICKS_PER_US, 50, clock cycles per microsecond (50 MHz clock).
PERIOD_US, 20000, PWM frame length in microseconds.
CENTER_US, 1500, pulse width for input 0.
RANGE_US, 500, pulse width deviation for input ±1.0.
CNT_W, 20, width of frame counter and width registers; must hold TICKS_PER_US*PERIOD_US.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_val  in  16  IEEE-754 half-precision activation value.
in_valid  in  1  in_val is valid this cycle.
in_ready  out  1  block can accept in_val.
pwm  out  1  servo pulse output.
frame_start  out  1  one-cycle strobe at the start of each frame.
pulse_ticks  out  CNT_W  width currently being generated, in clock ticks.

Behaviour:
- Derived constants:
  - PERIOD_T = TICKS_PER_US*PERIOD_US.
  - CENTER_T = TICKS_PER_US*CENTER_US.
  - RANGE_T = TICKS_PER_US*RANGE_US.
- Reset (async, rst_n=0):
  - Frame counter = 0; pwm = 0; frame_start = 0.
  - Active width = pending width = CENTER_T; pulse_ticks = CENTER_T.
  - pending_flag = 0; pipeline stages cleared; in_ready = 1.
- Handshake:
  - A transfer occurs on a rising edge with in_valid & in_ready.
  - in_ready is 0 while either pipeline stage holds data.
  - After accept edge E0, in_ready is low after E0 and after E1, and high again after E2. Throughput is 1 value per 3 cycles.
  - in_val is ignored when no transfer occurs.
- Pipeline:
  - E0: capture in_val.
  - E1, decode sign s, exponent e=[14:10], mantissa m=[9:0] into a magnitude mag (Q0.10, 0..1024):
    - e=0 (zero/subnormal): mag=0.
    - 1<=e<=14: mag = {1,m} >> (15-e), truncated.
    - e>=15 including infinity: mag=1024 (clamp).
    - NaN (e=31, m!=0): mag=0, sign forced positive.
  - E2: off = (mag*RANGE_T) >> 10, truncated. pending width = CENTER_T+off if s=0, else CENTER_T-off. pending_flag set.
  - -0 yields CENTER_T.
  - Multiple updates inside one frame: the last one wins.
- Frame counter:
  - Counts 0..PERIOD_T-1, then wraps to 0.
  - On the wrap edge (counter at PERIOD_T-1), if pending_flag: active width <= pending width, pulse_ticks updated, pending_flag cleared.
  - The wrap uses the pre-edge pending value and flag. A pending write on the same edge as the wrap waits for the next wrap.
- frame_start: registered, high for exactly the one cycle in which counter==0.
- pwm:
  - Registered: pwm <= (counter < active width).
  - pwm lags the counter by one cycle. Each frame's pulse is high for exactly active-width cycles, starting the cycle after frame_start asserts.
  - Active width never exceeds CENTER_T+RANGE_T < PERIOD_T, so pwm always returns low within the frame.
- Reset mid-frame or mid-pipeline: all state is immediately discarded, and output returns to center width from the first post-reset frame.

Test Plan:
All scenarios use TICKS_PER_US=1 (PERIOD_T=20000, CENTER_T=1500, RANGE_T=500).
1. Reset release with no input → frame_start every 20000 cycles; pwm high exactly 1500 cycles per frame; pulse_ticks=1500.
2. Send 16'h3c00 (1.0) mid-frame → current frame stays 1500; next frame pwm high 2000 cycles; pulse_ticks=2000.
3. Send each value, waiting one frame per value:
   - 16'h3800 → 1750.
   - 16'hb800 → 1250.
   - 16'hbc00 → 1000.
   - 16'h4000 → 2000 (clamp).
   - 16'hc000 → 1000 (clamp).
   - 16'h8000 → 1500.
   - 16'h7e00 (NaN) → 1500.
   - 16'hfc00 (-inf) → 1000.
4. Hold in_valid=1 continuously → in_ready pattern 1,0,0,1,0,0; send 16'h3800 then 16'hb800 in the same frame → next frame width 1250 only.
5. Time the E2 pending write to land on the wrap edge (counter=19999) → that frame stays at the old width; the new width appears one frame later.
6. Assert rst_n=0 while pwm is high and the pipeline is busy → pwm=0 and in_ready=1 immediately; after release, the first frame width is 1500.
